// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline register with registered in_ready and out_data.
// Optional bubble counter is enabled by defining PIPE_STAGE_BUBBLE_CNT_EN.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [15:0]       bubble_cnt
);

    // Encoding equals the entry count so occupancy comes straight from the state.
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              push, pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Payload is left alone; only the valid state is discarded.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (push && pop) begin
                        main_d = in_data;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d  = (state_d != StTwo);
        out_valid_d = (state_d != StEmpty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StEmpty;
            main_q      <= RST_VAL;
            skid_q      <= RST_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    logic [15:0] bubble_q;

    // Saturating count of cycles where downstream was ready but nothing was offered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= '0;
        end else if (out_ready && !out_valid_q && (bubble_q != 16'hFFFF)) begin
            bubble_q <= bubble_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; expected values are hand-computed.
// Bubble-counter checks follow PIPE_STAGE_BUBBLE_CNT_EN when it is defined.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_reg #(
        .DATA_W  (32),
        .RST_VAL (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [1:0] occ, input logic vld,
                               input logic rdy);
        check({tag, ".occ"}, {30'd0, occupancy}, {30'd0, occ});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, vld});
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;

        // Reset held for 3 cycles while upstream pushes; must be ignored.
        repeat (3) step();
        check_state("rst", 2'd0, 1'b0, 1'b1);
        check("rst.out_data", out_data, 32'h0);
        check("rst.bubble", {16'd0, bubble_cnt}, 32'h0);

        // Single push.
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        step();
        check_state("single", 2'd1, 1'b1, 1'b1);
        check("single.data", out_data, 32'hA5A5_0001);
        in_valid = 1'b0;
        step();
        check_state("single.drain", 2'd0, 1'b0, 1'b1);

        // Back-pressure: 0x11, 0x22 accepted, 0x33 held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        check_state("bp1", 2'd1, 1'b1, 1'b1);
        in_data = 32'h22;
        step();
        check_state("bp2", 2'd2, 1'b1, 1'b0);
        check("bp2.data", out_data, 32'h11);
        in_data = 32'h33;
        step();
        check_state("bp3", 2'd2, 1'b1, 1'b0);
        check("bp3.hold", out_data, 32'h11);
        out_ready = 1'b1;
        step();
        check_state("bp4", 2'd1, 1'b1, 1'b1);
        check("bp4.data", out_data, 32'h22);
        step();
        check_state("bp5", 2'd1, 1'b1, 1'b1);
        check("bp5.data", out_data, 32'h33);
        in_valid = 1'b0;
        step();
        check_state("bp6", 2'd0, 1'b0, 1'b1);

        // Streaming: 100 consecutive pushes, one entry out per cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'h1000 + i;
            step();
            check("stream.data", out_data, 32'h1000 + i);
            check("stream.valid", {31'd0, out_valid}, 32'd1);
            check("stream.ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check_state("stream.end", 2'd0, 1'b0, 1'b1);

        // Flush while full, with a same-cycle push that must be dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        step();
        in_data = 32'h55;
        step();
        check_state("fl.full", 2'd2, 1'b1, 1'b0);
        in_data = 32'h66;
        flush   = 1'b1;
        step();
        check_state("fl", 2'd0, 1'b0, 1'b1);
        check("fl.payload", out_data, 32'h44);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl.noemit", {31'd0, out_valid}, 32'd0);
        end

        // Flush in ONE with a pop in the same cycle.
        in_valid = 1'b1;
        in_data  = 32'h70;
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        check_state("fl1", 2'd0, 1'b0, 1'b1);
        flush = 1'b0;

        // Asynchronous reset mid-operation with two entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        step();
        in_data = 32'h88;
        step();
        check_state("ar.full", 2'd2, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_state("ar", 2'd0, 1'b0, 1'b1);
        check("ar.data", out_data, 32'h0);
        #1 rst = 1'b1;
        // First edge after release must accept a push.
        in_valid  = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b1;
        step();
        check_state("ar.push", 2'd1, 1'b1, 1'b1);
        check("ar.push.data", out_data, 32'h99);
        in_valid = 1'b0;
        step();
        check_state("ar.drain", 2'd0, 1'b0, 1'b1);

        // Bubble counting from a fresh reset.
        rst = 1'b0;
        step();
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (10) step();
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
        check("bubble10", {16'd0, bubble_cnt}, 32'd10);
        force dut.bubble_q = 16'hFFFE;
        step();
        release dut.bubble_q;
        repeat (3) step();
        check("bubble.sat", {16'd0, bubble_cnt}, 32'hFFFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("bubble.flush", {16'd0, bubble_cnt}, 32'hFFFF);
`else
        check("bubble.off", {16'd0, bubble_cnt}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
